sram_mem_responder: RTL
=======================

// Module: sram_mem_responder
// PURPOSE
//  Responder for the yari mem_* port: serves the CPU's initiator-side requests
//  (read/write, id-tagged reads) from the 1 MiB external async SRAM on the FSE
//  bus (two IDT71V416 x16 parts). Sits between yari_inst and fse_a/fse_d/sram_*;
//  replaces blockram in hardware builds.
// PARAMETERS
//  RD_WAIT    0   extra cycles sram_oe_n held low before read data capture
//  WR_WAIT    0   extra cycles sram_we_n held low per write
//  ADDR_BITS  18  SRAM word-address width (256 Ki x 32 = 1 MiB)
// PORTS
//  clock              in   1   system clock (25 MHz)
//  rst                in   1   synchronous, active-high reset
//  mem_waitrequest    out  1   1 = request this cycle not accepted
//  mem_id             in   2   read tag; 0 reserved (= no data)
//  mem_address        in   30  word address; only [ADDR_BITS-1:0] decoded (aliases)
//  mem_read           in   1   read request
//  mem_write          in   1   write request
//  mem_writedata      in   32  write data
//  mem_writedatamask  in   4   byte enables, 1 = write byte
//  mem_readdata       out  32  read data, valid when mem_readdataid != 0
//  mem_readdataid     out  2   tag of returned read; 0 = none this cycle
//  sram_a             out  23  FSE address; [19:2]=word addr, others 0
//  sram_d             inout 32 FSE data; driven only during write states
//  sram_cs_n/oe_n/we_n out 1   SRAM strobes, active low, registered
//  sram_be_n          out  4   byte enables, active low; all 0 on reads
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state IDLE; cs_n=oe_n=we_n=1, be_n=4'hF,
//    sram_a=0, sram_d hi-Z, mem_readdataid=0, mem_readdata=0, waitrequest=0.
//  - mem_waitrequest = (state != IDLE), combinational from state only.
//  - Accept on edge where state==IDLE and (mem_read|mem_write): latch address,
//    data, ~mask, id. read&write both high -> write wins, read ignored.
//  - States: IDLE, RD, WR_SETUP, WR, WR_HOLD. All strobes registered (no glitches).
//  - RD: cs_n=0, oe_n=0, be_n=0 for 1+RD_WAIT cycles; at last RD edge capture
//    sram_d into mem_readdata, mem_readdataid<=id, -> IDLE. readdataid high
//    exactly one cycle. Latency accept-edge -> data cycle = 2+RD_WAIT cycles.
//  - WR_SETUP: cs_n=0, we_n=1, addr/be_n/data driven (1 cycle).
//    WR: we_n=0 for 1+WR_WAIT cycles. WR_HOLD: we_n=1, addr/data still driven
//    (1 cycle) -> IDLE, bus released. Write occupancy = 3+WR_WAIT cycles.
//  - oe_n never low while sram_d driven; bus turnaround: sram_d hi-Z in IDLE/RD.
//  - Throughput: one request per (occupancy+1) cycles; accept only in IDLE.
//  - Wait counters width $clog2(max(RD_WAIT,WR_WAIT)+1), reload on state entry.
//  - mem_id=0 on read: performed, returns readdataid=0 (data effectively lost).
//  - rst mid-operation: transaction abandoned, pending read never returned,
//    strobes deasserted same edge, sram_d released.
// STRUCTURE
//  - Shared header (soclib): MEM_ID_NONE (2'd0), mem_* field widths, FSE/SRAM
//    base 4000_0000 and size constants.
//  - State encoding and wait counters local. Single module; no sub-module
//    (tristate is one continuous assign).
// TESTING (bench: two idt71v416s10 models on sram_a[19:2]/sram_d)
//  1 write addr 0x10 data 0xDEADBEEF mask 4'hF, then read id=1 -> readdata
//    0xDEADBEEF, readdataid=1 for one cycle, 2 cycles after read accept.
//  2 write 0x10 data 0x11223344 mask 4'b0101 over case 1 -> read = 0xDE22BE44.
//  3 back-to-back: read held high 3 requests ids 1,2,3 -> waitrequest pattern
//    0,1,0,1,0; ids returned in order 1,2,3, no duplicates.
//  4 RD_WAIT=2, WR_WAIT=1: oe_n low 3 cycles, we_n low 2; latency 4; checker
//    asserts sram_d never driven while oe_n=0.
//  5 read&write same cycle, addr 0x20 -> write performed, readdataid stays 0.
//  6 rst asserted in WR (and in RD) -> next edge all strobes 1, sram_d hi-Z,
//    readdataid 0, waitrequest 0; following read works normally.

Source files
------------

// File: rtl/sram_mem_responder_pkg.sv
// Shared mem_* / FSE bus constants for the SRAM responder and its neighbours.
package sram_mem_responder_pkg;
    localparam int unsigned MEM_ID_W   = 2;
    localparam int unsigned MEM_ADDR_W = 30;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_MASK_W = 4;
    localparam int unsigned FSE_ADDR_W = 23;

    localparam logic [MEM_ID_W-1:0] MEM_ID_NONE = 2'd0;

    localparam logic [31:0] SRAM_BASE = 32'h4000_0000;
    localparam logic [31:0] SRAM_SIZE = 32'h0010_0000;
endpackage

// File: rtl/sram_mem_responder.sv
// Serves yari mem_* read/write requests from the 32-bit async SRAM on the FSE bus.
// All SRAM strobes are registered; sram_d is driven only while a write is in flight.
module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter int unsigned RD_WAIT   = 0,
    parameter int unsigned WR_WAIT   = 0,
    parameter int unsigned ADDR_BITS = 18
) (
    input  logic                  clock,
    input  logic                  rst,
    output logic                  mem_waitrequest,
    input  logic [MEM_ID_W-1:0]   mem_id,
    input  logic [MEM_ADDR_W-1:0] mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_DATA_W-1:0] mem_writedata,
    input  logic [MEM_MASK_W-1:0] mem_writedatamask,
    output logic [MEM_DATA_W-1:0] mem_readdata,
    output logic [MEM_ID_W-1:0]   mem_readdataid,
    output logic [FSE_ADDR_W-1:0] sram_a,
    inout  wire  [MEM_DATA_W-1:0] sram_d,
    output logic                  sram_cs_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [MEM_MASK_W-1:0] sram_be_n
);

    typedef enum logic [2:0] {StIdle, StRd, StWrSetup, StWr, StWrHold} state_e;

    localparam int unsigned WaitMax = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned CntW    = (WaitMax > 0) ? $clog2(WaitMax + 1) : 1;
    localparam logic [CntW-1:0] RdLoad = CntW'(RD_WAIT);
    localparam logic [CntW-1:0] WrLoad = CntW'(WR_WAIT);

    function automatic logic [FSE_ADDR_W-1:0] fse_addr(input logic [ADDR_BITS-1:0] a);
        logic [FSE_ADDR_W-1:0] f;
        f = '0;
        f[ADDR_BITS+1:2] = a;
        return f;
    endfunction

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [MEM_DATA_W-1:0]   wdata_q, wdata_d;
    logic [MEM_MASK_W-1:0]   wbe_n_q, wbe_n_d;
    logic [MEM_ID_W-1:0]     id_q, id_d;
    logic [MEM_DATA_W-1:0]   rdata_q, rdata_d;
    logic [MEM_ID_W-1:0]     rdid_q, rdid_d;
    logic                    cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [MEM_MASK_W-1:0]   be_n_q, be_n_d;
    logic [FSE_ADDR_W-1:0]   a_q, a_d;
    logic                    drive_q, drive_d;
    logic                    unused_addr;

    assign unused_addr = ^mem_address[MEM_ADDR_W-1:ADDR_BITS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wbe_n_d = wbe_n_q;
        id_d    = id_q;
        rdata_d = rdata_q;
        rdid_d  = MEM_ID_NONE;
        unique case (state_q)
            StIdle: begin
                if (mem_write || mem_read) begin
                    addr_d  = mem_address[ADDR_BITS-1:0];
                    wdata_d = mem_writedata;
                    wbe_n_d = ~mem_writedatamask;
                    id_d    = mem_id;
                    // A simultaneous read is dropped: the write takes the slot.
                    if (mem_write) begin
                        state_d = StWrSetup;
                    end else begin
                        state_d = StRd;
                        cnt_d   = RdLoad;
                    end
                end
            end
            StRd: begin
                if (cnt_q == '0) begin
                    rdata_d = sram_d;
                    rdid_d  = id_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrSetup: begin
                state_d = StWr;
                cnt_d   = WrLoad;
            end
            StWr: begin
                if (cnt_q == '0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Strobes are decoded from the next state so the pins come straight off flops.
    always_comb begin
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        drive_d = 1'b0;
        a_d     = a_q;
        unique case (state_d)
            StRd: begin
                cs_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
                a_d    = fse_addr(addr_d);
            end
            StWrSetup, StWr, StWrHold: begin
                cs_n_d  = 1'b0;
                we_n_d  = (state_d != StWr);
                be_n_d  = wbe_n_d;
                drive_d = 1'b1;
                a_d     = fse_addr(addr_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wbe_n_q <= '1;
            id_q    <= MEM_ID_NONE;
            rdata_q <= '0;
            rdid_q  <= MEM_ID_NONE;
            cs_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= '1;
            a_q     <= '0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbe_n_q <= wbe_n_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            rdid_q  <= rdid_d;
            cs_n_q  <= cs_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            a_q     <= a_d;
            drive_q <= drive_d;
        end
    end

    assign mem_waitrequest = (state_q != StIdle);
    assign mem_readdata    = rdata_q;
    assign mem_readdataid  = rdid_q;
    assign sram_a          = a_q;
    assign sram_cs_n       = cs_n_q;
    assign sram_oe_n       = oe_n_q;
    assign sram_we_n       = we_n_q;
    assign sram_be_n       = be_n_q;
    assign sram_d          = drive_q ? wdata_q : 'z;

endmodule
